seg_capture_decoder: RTL

Receive-side counterpart of the hex-to-seven-segment driver. Samples a multiplexed, active-low seven-segment bus (segments plus per-digit anode selects), waits until a pattern has been stable for a programmable number of cycles, and decodes it back to a 4-bit hex value per digit. It is used in loopback self-test and board bring-up to check that the display path shows what the core intended.

---
 rtl/seg_pkg.sv | 31 +++
 rtl/seg_glyph_decode.sv | 39 +++
 rtl/seg_capture_decoder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: active-low glyph codes (GFEDCBA),
// decimal-point bit position and the capture FSM state type.
package seg_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam int unsigned DP_BIT = 7;

   typedef enum logic [1:0] {
      S_IDLE,
      S_TRACK,
      S_HELD
   } state_e;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational glyph decoder: active-low GFEDCBA pattern to hex value,
// with flags for the blank pattern and for unrecognised patterns.
module seg_glyph_decode
   import seg_pkg::*;
(
   input  logic [6:0] seg_n,
   output logic [3:0] value,
   output logic       is_blank,
   output logic       is_err
);

   // Map each legal glyph to its value; anything else is an error.
   always_comb begin
      value    = '0;
      is_blank = 1'b0;
      is_err   = 1'b0;
      case (seg_n)
         SEG_0:     value = 4'h0;
         SEG_1:     value = 4'h1;
         SEG_2:     value = 4'h2;
         SEG_3:     value = 4'h3;
         SEG_4:     value = 4'h4;
         SEG_5:     value = 4'h5;
         SEG_6:     value = 4'h6;
         SEG_7:     value = 4'h7;
         SEG_8:     value = 4'h8;
         SEG_9:     value = 4'h9;
         SEG_A:     value = 4'hA;
         SEG_B:     value = 4'hB;
         SEG_C:     value = 4'hC;
         SEG_D:     value = 4'hD;
         SEG_E:     value = 4'hE;
         SEG_F:     value = 4'hF;
         SEG_BLANK: is_blank = 1'b1;
         default:   is_err = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg_capture_decoder.sv
// Samples a multiplexed active-low seven-segment bus, waits for a
// (segment, anode) pattern to be stable, then decodes it into per-digit
// hex value, validity and decimal-point registers.
module seg_capture_decoder
   import seg_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned DIGITS        = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            seg_n,
   input  logic [DIGITS-1:0]     an_n,
   output logic [4*DIGITS-1:0]   digits,
   output logic [DIGITS-1:0]     digit_valid,
   output logic [DIGITS-1:0]     dp,
   output logic                  cap_stb,
   output logic [1:0]            cap_idx,
   output logic                  cap_err
);

   localparam logic [3:0] STABLE_CNT = 4'(STABLE_CYCLES);

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [7:0]            seg_q, seg_d;
   logic [DIGITS-1:0]     an_q, an_d;
   logic [4*DIGITS-1:0]   digits_q, digits_d;
   logic [DIGITS-1:0]     digit_valid_q, digit_valid_d;
   logic [DIGITS-1:0]     dp_q, dp_d;
   logic                  cap_stb_q, cap_stb_d;
   logic [1:0]            cap_idx_q, cap_idx_d;
   logic                  cap_err_q, cap_err_d;

   logic [1:0]            an_idx;
   logic                  in_valid;
   logic                  in_change;
   logic                  capture;
   logic [3:0]            glyph_val;
   logic                  glyph_blank;
   logic                  glyph_err;

   seg_glyph_decode u_glyph (
      .seg_n    (seg_q[6:0]),
      .value    (glyph_val),
      .is_blank (glyph_blank),
      .is_err   (glyph_err)
   );

   // Digit index of the registered sample's active anode.
   always_comb begin
      an_idx = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (!an_q[i]) an_idx = i[1:0];
      end
   end

   // Next-state logic: stability tracking, FSM and capture updates.
   // Change detection compares the incoming bus with the held sample, so
   // cnt_q/state_q always describe the sample currently in seg_q/an_q and
   // the capture decision never depends on the bus at the capture edge.
   always_comb begin
      seg_d         = seg_n;
      an_d          = an_n;
      state_d       = state_q;
      cnt_d         = cnt_q;
      digits_d      = digits_q;
      digit_valid_d = digit_valid_q;
      dp_d          = dp_q;
      cap_stb_d     = 1'b0;
      cap_idx_d     = cap_idx_q;
      cap_err_d     = cap_err_q;

      in_valid  = $onehot(~an_n);
      in_change = ({seg_n, an_n} != {seg_q, an_q});
      capture   = (state_q == S_TRACK) && (cnt_q == STABLE_CNT);

      if (!in_valid) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else if (in_change) begin
         state_d = S_TRACK;
         cnt_d   = 4'd1;
      end else begin
         case (state_q)
            S_TRACK: begin
               if (capture)                 state_d = S_HELD;
               else if (cnt_q != STABLE_CNT) cnt_d   = cnt_q + 4'd1;
            end
            default: state_d = state_q;
         endcase
      end

      if (capture) begin
         cap_stb_d = 1'b1;
         cap_idx_d = an_idx;
         cap_err_d = glyph_err;
         for (int unsigned i = 0; i < DIGITS; i++) begin
            if (i[1:0] == an_idx) begin
               digits_d[4*i +: 4] = (glyph_blank || glyph_err) ? 4'h0 : glyph_val;
               digit_valid_d[i]   = !(glyph_blank || glyph_err);
               dp_d[i]            = ~seg_q[DP_BIT];
            end
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         seg_q         <= '1;
         an_q          <= '1;
         digits_q      <= '0;
         digit_valid_q <= '0;
         dp_q          <= '0;
         cap_stb_q     <= 1'b0;
         cap_idx_q     <= '0;
         cap_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         seg_q         <= seg_d;
         an_q          <= an_d;
         digits_q      <= digits_d;
         digit_valid_q <= digit_valid_d;
         dp_q          <= dp_d;
         cap_stb_q     <= cap_stb_d;
         cap_idx_q     <= cap_idx_d;
         cap_err_q     <= cap_err_d;
      end
   end

   assign digits      = digits_q;
   assign digit_valid = digit_valid_q;
   assign dp          = dp_q;
   assign cap_stb     = cap_stb_q;
   assign cap_idx     = cap_idx_q;
   assign cap_err     = cap_err_q;

endmodule
